uart_txq: RTL and testbench
===========================

UART_TXQ -- requirements
Module: uart_txq

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes (legal 2..8).
REQ-002 The block SHALL have parameter POLL_GAP, default 2, idle cycles between a not-ready status read and the next poll (legal 0..15).
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-high; ports wb_clk_i and wb_rst_i.
REQ-004 wb_clk_i  in  1  system clock; all state on rising edge.
REQ-005 wb_rst_i  in  1  asynchronous active-high reset.
REQ-006 dat_i  in  8  byte to enqueue.
REQ-007 push_i  in  1  enqueue strobe, one byte per cycle.
REQ-008 full_o  out  1  FIFO holds DEPTH bytes.
REQ-009 empty_o  out  1  FIFO holds 0 bytes.
REQ-010 count_o  out  DEPTH_LOG2+1  current fill level.
REQ-011 ovf_o  out  1  sticky: push attempted while full.
REQ-012 m_adr_o  out  1  Wishbone master address to UART (0 = data, 1 = status).
REQ-013 m_dat_o  out  8  byte written to UART data register.
REQ-014 m_dat_i  in  8  UART read data; bit 0 = transmitter ready.
REQ-015 m_we_o  out  1  Wishbone write enable.
REQ-016 m_stb_o  out  1  Wishbone strobe; held until m_ack_i.
REQ-017 m_ack_i  in  1  Wishbone acknowledge; may be combinational from m_stb_o.

Function
REQ-018 Push SHALL enqueue dat_i when push_i=1 and full_o=0; when full_o=1 the byte SHALL be dropped and ovf_o set.
REQ-019 full_o, empty_o and count_o SHALL be registered and reflect the FIFO state after the previous edge.
REQ-020 Same-cycle push and pop SHALL leave count_o unchanged; full_o is sampled before the pop, so a push while full is dropped even if a pop occurs.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH without gaps.
REQ-022 FSM states: IDLE, POLL, GAP, WRITE, SETTLE.
REQ-023 IDLE: all master outputs 0; when empty_o=0, go to POLL.
REQ-024 POLL: m_stb_o=1, m_we_o=0, m_adr_o=1.
REQ-025 POLL on m_ack_i: if m_dat_i[0]=1, go to WRITE; otherwise go to GAP.
REQ-026 GAP: stay POLL_GAP cycles with strobe low, then go to POLL; with POLL_GAP=0, go directly to POLL.
REQ-027 WRITE: m_stb_o=1, m_we_o=1, m_adr_o=0, m_dat_o=FIFO head; on m_ack_i, pop one byte and go to SETTLE.
REQ-028 SETTLE: hold strobe low for exactly 2 cycles so the UART busy flag becomes valid, then go to IDLE.
REQ-029 Byte-to-wire order SHALL be FIFO order; each byte SHALL be written exactly once.
REQ-030 Minimum latency from push into an empty FIFO to the WRITE strobe SHALL be 3 cycles with zero-wait ack and UART ready.

Reset
REQ-031 On wb_rst_i, without waiting for a clock edge: FIFO emptied, count_o=0, empty_o=1, full_o=0, ovf_o=0, FSM=IDLE, all m_* outputs 0.
REQ-032 Reset mid-transfer SHALL abandon the cycle; the byte in flight SHALL be discarded.
REQ-033 ovf_o SHALL clear only on reset (or on flush when compiled in).

Configuration
REQ-034 Macro UART_TXQ_FLUSH_EN defined: add input flush_i (1 bit); flush_i=1 synchronously empties the FIFO, clears ovf_o, and returns the FSM to IDLE once any active strobe is acknowledged.
REQ-035 Macro UART_TXQ_FLUSH_EN undefined: no flush_i port and no flush logic.

Structure
REQ-036 Package uart_txq_pkg SHALL hold the FSM state enumeration, the ADR_DATA=0 and ADR_STATUS=1 constants, and the STATUS_TXRDY_BIT=0 constant.
REQ-037 Storage SHALL be sub-module uart_txq_fifo (synchronous FIFO, registered flags); the FSM SHALL live in uart_txq.

Verification
REQ-038 Scenario: push 0x41, 0x42, 0x43; UART always ready, ack=stb -> three writes with m_dat_o 0x41, 0x42, 0x43 in order, each preceded by a status read, and empty_o=1 at the end.
REQ-039 Scenario: status returns 0x00 five times then 0x01, POLL_GAP=2 -> six polls spaced by 2 idle cycles, then one write.
REQ-040 Scenario: push 17 bytes with DEPTH_LOG2=4 while the UART is stalled -> count_o=16, full_o=1, ovf_o=1, 17th byte never transmitted.
REQ-041 Scenario: push while full with a same-cycle WRITE ack -> push dropped, count_o goes 16 to 15.
REQ-042 Scenario: assert reset during WRITE with a 3-cycle ack delay -> outputs 0 immediately, count_o=0, no further strobes.
REQ-043 Scenario: with UART_TXQ_FLUSH_EN defined, 5 bytes queued then flush_i pulse -> count_o=0, ovf_o=0, FSM in IDLE.

Source files
------------

// File: rtl/uart_txq_pkg.sv
// Shared definitions for the UART transmit queue: FSM states and Wishbone
// register map of the downstream UART.
package uart_txq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POLL,
      GAP,
      WRITE,
      SETTLE
   } state_t;

   localparam logic ADR_DATA         = 1'b0;
   localparam logic ADR_STATUS       = 1'b1;
   localparam int   STATUS_TXRDY_BIT = 0;

endpackage

// File: rtl/uart_txq_if.sv
// Wishbone master link from the transmit queue to the UART register block.
interface uart_txq_if;

   logic       m_adr_o;
   logic [7:0] m_dat_o;
   logic [7:0] m_dat_i;
   logic       m_we_o;
   logic       m_stb_o;
   logic       m_ack_i;

   modport master (
      output m_adr_o, m_dat_o, m_we_o, m_stb_o,
      input  m_dat_i, m_ack_i
   );

   modport slave (
      input  m_adr_o, m_dat_o, m_we_o, m_stb_o,
      output m_dat_i, m_ack_i
   );

endinterface

// File: rtl/uart_txq_fifo.sv
// Synchronous byte FIFO with registered flags and a registered head read.
// Optional synchronous clear when UART_TXQ_FLUSH_EN is defined.
module uart_txq_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [7:0]            wr_data,
   input  logic                  push,
   input  logic                  pop,
`ifdef UART_TXQ_FLUSH_EN
   input  logic                  flush,
`endif
   output logic [7:0]            head,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  ovf
);

   localparam int                  DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   logic [7:0]            mem [DEPTH];
   logic [7:0]            head_reg;
   logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
   logic [DEPTH_LOG2:0]   count_reg, count_next;
   logic                  full_reg, full_next, empty_reg, empty_next;
   logic                  ovf_reg, ovf_next;
   logic                  do_push, do_pop, clear;

`ifdef UART_TXQ_FLUSH_EN
   assign clear = flush;
`else
   assign clear = 1'b0;
`endif

   // Flags are judged on the registered state, so a push while full is
   // dropped even when a pop lands in the same cycle.
   assign do_push = push && !full_reg && !clear;
   assign do_pop  = pop && !empty_reg && !clear;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (do_push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
      if (do_push && !do_pop)      count_next = count_reg + CNT_ONE;
      else if (!do_push && do_pop) count_next = count_reg - CNT_ONE;
      if (clear) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end
      full_next  = (count_next == CNT_FULL);
      empty_next = (count_next == '0);
      ovf_next   = clear ? 1'b0 : (ovf_reg || (push && full_reg));
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
         ovf_reg    <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         full_reg   <= full_next;
         empty_reg  <= empty_next;
         ovf_reg    <= ovf_next;
      end
   end

   // Head may lag a fresh write by one cycle; the FSM never reaches WRITE
   // sooner than two cycles after the FIFO becomes non-empty or after a pop.
   always_ff @(posedge wb_clk_i) begin
      if (do_push) mem[wr_ptr_reg] <= wr_data;
      head_reg <= mem[rd_ptr_next];
   end

   assign head  = head_reg;
   assign full  = full_reg;
   assign empty = empty_reg;
   assign count = count_reg;
   assign ovf   = ovf_reg;

endmodule

// File: rtl/uart_txq.sv
// Byte queue that drains into a Wishbone UART: poll status, write when ready.
// Optional flush input when UART_TXQ_FLUSH_EN is defined.
module uart_txq
   import uart_txq_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int POLL_GAP   = 2
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic [7:0]          dat_i,
   input  logic                push_i,
`ifdef UART_TXQ_FLUSH_EN
   input  logic                flush_i,
`endif
   output logic                full_o,
   output logic                empty_o,
   output logic [DEPTH_LOG2:0] count_o,
   output logic                ovf_o,
   uart_txq_if.master          m
);

   localparam logic [3:0] GAP_LAST = 4'(POLL_GAP > 0 ? POLL_GAP - 1 : 0);

   state_t     state_reg, state_next;
   logic [3:0] cnt_reg, cnt_next;
   logic [7:0] head;
   logic       pop, flushing;
   logic       m_stb, m_we, m_adr;
   logic [7:0] m_dat;
   logic       unused_status;

   assign unused_status = ^m.m_dat_i[7:1];

   uart_txq_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .wr_data  (dat_i),
      .push     (push_i),
      .pop      (pop),
`ifdef UART_TXQ_FLUSH_EN
      .flush    (flush_i),
`endif
      .head     (head),
      .full     (full_o),
      .empty    (empty_o),
      .count    (count_o),
      .ovf      (ovf_o)
   );

`ifdef UART_TXQ_FLUSH_EN
   // A flush that hits an open bus cycle is remembered until the ack arrives.
   logic flush_pend_reg, flush_pend_next;
   assign flushing        = flush_i || flush_pend_reg;
   assign flush_pend_next = flushing && m_stb && !m.m_ack_i;
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) flush_pend_reg <= 1'b0;
      else          flush_pend_reg <= flush_pend_next;
   end
`else
   assign flushing = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = '0;
      pop        = 1'b0;
      m_stb      = 1'b0;
      m_we       = 1'b0;
      m_adr      = ADR_DATA;
      m_dat      = 8'h00;
      case (state_reg)
         IDLE: begin
            if (!empty_o && !flushing) state_next = POLL;
         end
         POLL: begin
            m_stb = 1'b1;
            m_adr = ADR_STATUS;
            if (m.m_ack_i) begin
               if (flushing)                          state_next = IDLE;
               else if (m.m_dat_i[STATUS_TXRDY_BIT])  state_next = WRITE;
               else if (POLL_GAP == 0)                state_next = POLL;
               else                                   state_next = GAP;
            end
         end
         GAP: begin
            if (flushing)                 state_next = IDLE;
            else if (cnt_reg == GAP_LAST) state_next = POLL;
            else                          cnt_next   = cnt_reg + 4'd1;
         end
         WRITE: begin
            m_stb = 1'b1;
            m_we  = 1'b1;
            m_adr = ADR_DATA;
            m_dat = head;
            if (m.m_ack_i) begin
               pop        = !flushing;
               state_next = flushing ? IDLE : SETTLE;
            end
         end
         SETTLE: begin
            // Two quiet cycles let the UART busy flag catch up with the write.
            if (flushing || cnt_reg == 4'd1) state_next = IDLE;
            else                             cnt_next   = cnt_reg + 4'd1;
         end
         default: state_next = IDLE;
      endcase
   end

   assign m.m_stb_o = m_stb;
   assign m.m_we_o  = m_we;
   assign m.m_adr_o = m_adr;
   assign m.m_dat_o = m_dat;

endmodule

// File: tb/tb_uart_txq.sv
// Scoreboard bench for uart_txq: directed scenarios push bytes and expected
// writes; a monitor checks every Wishbone handshake against the queue.
module tb_uart_txq;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic [7:0] dat_i   = 8'h00;
   logic       push_i  = 1'b0;
`ifdef UART_TXQ_FLUSH_EN
   logic       flush_i = 1'b0;
`endif
   logic       full_o, empty_o, ovf_o;
   logic [4:0] count_o;

   int  n_cmp = 0, n_err = 0, n_writes = 0, cyc = 0;
   int  polls_total = 0, nr_base = 0, nr_count = 0;
   int  ack_delay = 0, wait_cnt = 0;
   bit  stall = 1'b0, rdy_seen = 1'b0;
   logic [7:0] exp_q[$];
   int  poll_cyc_q[$];

   uart_txq_if bus ();

   uart_txq #(.DEPTH_LOG2(4), .POLL_GAP(2)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .dat_i    (dat_i),
      .push_i   (push_i),
`ifdef UART_TXQ_FLUSH_EN
      .flush_i  (flush_i),
`endif
      .full_o   (full_o),
      .empty_o  (empty_o),
      .count_o  (count_o),
      .ovf_o    (ovf_o),
      .m        (bus)
   );

   always #5 clk = ~clk;

   // UART model: ack after ack_delay strobe cycles; status not-ready for
   // nr_count polls after nr_base, or permanently while stalled.
   assign bus.m_ack_i = bus.m_stb_o && (wait_cnt >= ack_delay);
   assign bus.m_dat_i = {7'b0, (!stall && ((polls_total - nr_base) >= nr_count))};

   function automatic void chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [7:0] b, input bit keep);
      dat_i  = b;
      push_i = 1'b1;
      if (keep) exp_q.push_back(b);
      tick();
      push_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || !empty_o || bus.m_stb_o) && k < 400) begin
         tick();
         k++;
      end
      chk({name, "_drain_in_time"}, int'(k < 400), 1);
      repeat (4) tick();
   endtask

   task automatic wait_write(input string name);
      int k;
      k = 0;
      while (!(bus.m_stb_o && bus.m_we_o) && k < 100) begin
         tick();
         k++;
      end
      chk({name, "_write_seen"}, int'(k < 100), 1);
   endtask

   // Bus model state update, applied just after the edge the DUT sampled.
   initial forever begin
      int nxt;
      bit poll_hs;
      @(negedge clk);
      nxt     = (bus.m_stb_o && !bus.m_ack_i) ? wait_cnt + 1 : 0;
      poll_hs = !rst && bus.m_stb_o && bus.m_ack_i && !bus.m_we_o;
      @(posedge clk);
      #1;
      wait_cnt = nxt;
      cyc++;
      if (poll_hs) polls_total++;
   end

   // Monitor: one line per Wishbone handshake, writes checked against exp_q.
   initial forever begin
      @(negedge clk);
      if (!rst && bus.m_stb_o && bus.m_ack_i) begin
         if (!bus.m_we_o) begin
            $display("[cyc %0d] status read adr=%0d rdy=%0b", cyc, bus.m_adr_o, bus.m_dat_i[0]);
            chk("poll_adr", int'(bus.m_adr_o), 1);
            poll_cyc_q.push_back(cyc);
            rdy_seen = bus.m_dat_i[0];
         end else begin
            $display("[cyc %0d] data write adr=%0d dat=0x%02h", cyc, bus.m_adr_o, bus.m_dat_o);
            chk("write_adr", int'(bus.m_adr_o), 0);
            chk("ready_poll_before_write", int'(rdy_seen), 1);
            rdy_seen = 1'b0;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_write: got 0x%02h, expected no write", bus.m_dat_o);
            end else begin
               chk("write_data", int'(bus.m_dat_o), int'(exp_q.pop_front()));
            end
            n_writes++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, w0, saw;

      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_count", int'(count_o), 0);
      chk("rst_empty", int'(empty_o), 1);
      chk("rst_full", int'(full_o), 0);
      chk("rst_ovf", int'(ovf_o), 0);
      chk("rst_stb", int'(bus.m_stb_o), 0);

      // Three bytes in order, UART always ready
      w0 = n_writes;
      push(8'h41, 1'b1);
      push(8'h42, 1'b1);
      push(8'h43, 1'b1);
      drain("abc");
      chk("abc_writes", n_writes - w0, 3);
      chk("abc_empty", int'(empty_o), 1);
      chk("abc_count", int'(count_o), 0);

      // Push-to-WRITE latency into an empty FIFO
      push(8'h11, 1'b1);
      lat = 1;
      while (!(bus.m_stb_o && bus.m_we_o) && lat < 20) begin
         tick();
         lat++;
      end
      chk("latency_cycles", lat, 3);
      drain("lat");

      // Five not-ready polls then ready; polls spaced by POLL_GAP idle cycles
      nr_base  = polls_total;
      nr_count = 5;
      poll_cyc_q.delete();
      w0 = n_writes;
      push(8'h55, 1'b1);
      drain("gap");
      chk("gap_poll_count", poll_cyc_q.size(), 6);
      for (int i = 1; i < poll_cyc_q.size(); i++)
         chk("gap_poll_spacing", poll_cyc_q[i] - poll_cyc_q[i-1], 3);
      chk("gap_writes", n_writes - w0, 1);

      // Overfill while stalled: 17th byte dropped
      stall = 1'b1;
      for (int i = 0; i < 16; i++) push(8'(8'h60 + i), 1'b1);
      chk("fill16_full", int'(full_o), 1);
      chk("fill16_ovf", int'(ovf_o), 0);
      push(8'h70, 1'b0);
      chk("ovf_count", int'(count_o), 16);
      chk("ovf_full", int'(full_o), 1);
      chk("ovf_flag", int'(ovf_o), 1);

      // Push while full in the same cycle as a WRITE ack: dropped, 16 -> 15
      w0 = n_writes;
      stall = 1'b0;
      wait_write("popfull");
      dat_i  = 8'hEE;
      push_i = 1'b1;
      tick();
      push_i = 1'b0;
      chk("popfull_count", int'(count_o), 15);
      chk("popfull_full", int'(full_o), 0);
      chk("popfull_ovf_sticky", int'(ovf_o), 1);
      drain("popfull");
      chk("popfull_writes", n_writes - w0, 16);
      chk("popfull_empty", int'(empty_o), 1);

      // Reset during a WRITE with slow ack: byte abandoned
      ack_delay = 3;
      w0 = n_writes;
      push(8'h99, 1'b0);
      wait_write("rstmid");
      #1 rst = 1'b1;
      #1;
      chk("rstmid_stb", int'(bus.m_stb_o), 0);
      chk("rstmid_we", int'(bus.m_we_o), 0);
      chk("rstmid_adr", int'(bus.m_adr_o), 0);
      chk("rstmid_dat", int'(bus.m_dat_o), 0);
      chk("rstmid_count", int'(count_o), 0);
      chk("rstmid_empty", int'(empty_o), 1);
      chk("rstmid_ovf", int'(ovf_o), 0);
      tick();
      tick();
      rst = 1'b0;
      ack_delay = 0;
      saw = 0;
      repeat (20) begin
         tick();
         if (bus.m_stb_o) saw = 1;
      end
      chk("rstmid_no_strobe", saw, 0);
      chk("rstmid_no_write", n_writes - w0, 0);

`ifdef UART_TXQ_FLUSH_EN
      // Flush with five queued bytes while stalled
      stall = 1'b1;
      for (int i = 0; i < 5; i++) push(8'(8'hA0 + i), 1'b0);
      chk("flush_pre_count", int'(count_o), 5);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_count", int'(count_o), 0);
      chk("flush_empty", int'(empty_o), 1);
      chk("flush_ovf", int'(ovf_o), 0);
      repeat (3) tick();
      chk("flush_idle_stb", int'(bus.m_stb_o), 0);
      stall = 1'b0;
      repeat (10) tick();
`endif

      chk("exp_queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
